// File: rtl/traffic_light_ctrl_param.sv
// Two-road traffic light controller with 1 s prescaler, all-red clearance, pedestrian
// green shortening, active-low 7-segment countdown and phase blinker. Optional macro: NIGHT_FLASH_EN.
module traffic_light_ctrl_param #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int GREEN_SEC     = 6,
  parameter int YELLOW_SEC    = 3,
  parameter int ALLRED_SEC    = 1,
  parameter int PED_SEC       = 2,
  parameter int SLOW_HALF     = 25000000,
  parameter int FAST_HALF     = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic [2:0] LightA,
  output logic [2:0] LightB,
  output logic [0:6] HEX,
  output logic       LED,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GREEN = 3'd0, A_YELLOW = 3'd1, RED_AB = 3'd2,
    B_GREEN = 3'd3, B_YELLOW = 3'd4, RED_BA = 3'd5, NIGHT = 3'd6
  } state_t;

  localparam int PW      = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int LED_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int LW      = (LED_MAX > 2) ? $clog2(LED_MAX) : 1;
  localparam int SW      = 4;

  state_t        state, state_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [SW-1:0] sec, sec_nxt;
  logic [LW-1:0] cnt, cnt_nxt, half_last;
  logic          ped_pend, ped_nxt, led, led_nxt, tick, green;
  logic [2:0]    la_nxt, lb_nxt;
  logic [0:6]    hex_nxt;
`ifdef NIGHT_FLASH_EN
  logic          flash, flash_nxt;
`endif

  function automatic state_t succ(input state_t s);
    case (s)
      A_GREEN:  succ = A_YELLOW;
      A_YELLOW: succ = RED_AB;
      RED_AB:   succ = B_GREEN;
      B_GREEN:  succ = B_YELLOW;
      B_YELLOW: succ = RED_BA;
      default:  succ = A_GREEN;
    endcase
  endfunction

  function automatic logic [SW-1:0] dur(input state_t s);
    case (s)
      A_GREEN, B_GREEN:   dur = SW'(GREEN_SEC);
      A_YELLOW, B_YELLOW: dur = SW'(YELLOW_SEC);
      default:            dur = SW'(ALLRED_SEC);
    endcase
  endfunction

  function automatic logic [0:6] digit(input logic [SW-1:0] d);
    case (d)
      4'd0:    digit = 7'b0000001;
      4'd1:    digit = 7'b1001111;
      4'd2:    digit = 7'b0010010;
      4'd3:    digit = 7'b0000110;
      4'd4:    digit = 7'b1001100;
      4'd5:    digit = 7'b0100100;
      4'd6:    digit = 7'b0100000;
      4'd7:    digit = 7'b0001111;
      4'd8:    digit = 7'b0000000;
      4'd9:    digit = 7'b0000100;
      default: digit = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= A_GREEN;
      pre      <= '0;
      sec      <= SW'(GREEN_SEC);
      ped_pend <= 1'b0;
      cnt      <= '0;
      led      <= 1'b0;
      LightA   <= 3'b001;
      LightB   <= 3'b100;
      HEX      <= digit(SW'(GREEN_SEC));
`ifdef NIGHT_FLASH_EN
      flash    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      pre      <= pre_nxt;
      sec      <= sec_nxt;
      ped_pend <= ped_nxt;
      cnt      <= cnt_nxt;
      led      <= led_nxt;
      LightA   <= la_nxt;
      LightB   <= lb_nxt;
      HEX      <= hex_nxt;
`ifdef NIGHT_FLASH_EN
      flash    <= flash_nxt;
`endif
    end
  end

  always_comb begin
    tick      = (pre == PW'(TICKS_PER_SEC - 1));
    pre_nxt   = tick ? '0 : pre + 1'b1;
    state_nxt = state;
    sec_nxt   = sec;
    ped_nxt   = ped_pend | ped_req;
    green     = (state == A_GREEN) || (state == B_GREEN);
    if (green && ped_pend)
      ped_nxt = ped_req;
    // Truncation wins over a coincident tick: no decrement in that cycle.
    if (green && ped_pend && (sec > SW'(PED_SEC))) begin
      sec_nxt = SW'(PED_SEC);
    end else if (tick) begin
      if (sec == SW'(1)) begin
        state_nxt = succ(state);
        sec_nxt   = dur(succ(state));
      end else begin
        sec_nxt = sec - 1'b1;
      end
    end
`ifdef NIGHT_FLASH_EN
    flash_nxt = flash;
    if (state == NIGHT) begin
      ped_nxt   = 1'b0;
      state_nxt = NIGHT;
      sec_nxt   = sec;
      if (tick) begin
        if (night) begin
          flash_nxt = ~flash;
        end else begin
          state_nxt = RED_BA;
          sec_nxt   = SW'(ALLRED_SEC);
        end
      end
    end else if (tick && night) begin
      state_nxt = NIGHT;
      sec_nxt   = sec;
      ped_nxt   = 1'b0;
      flash_nxt = 1'b1;
    end
`endif
    // Blinker counter restarts on any phase change; level is held across the change.
    half_last = ((state == A_YELLOW) || (state == B_YELLOW)) ? LW'(FAST_HALF - 1) : LW'(SLOW_HALF - 1);
    led_nxt   = led;
    cnt_nxt   = cnt + 1'b1;
    if ((state_nxt == RED_AB) || (state_nxt == RED_BA) || (state_nxt == NIGHT)) begin
      led_nxt = 1'b0;
      cnt_nxt = '0;
    end else if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (cnt == half_last) begin
      led_nxt = ~led;
      cnt_nxt = '0;
    end
  end

  always_comb begin
    la_nxt  = 3'b100;
    lb_nxt  = 3'b100;
    hex_nxt = digit(sec_nxt);
    case (state_nxt)
      A_GREEN:  la_nxt = 3'b001;
      A_YELLOW: la_nxt = 3'b010;
      B_GREEN:  lb_nxt = 3'b001;
      B_YELLOW: lb_nxt = 3'b010;
`ifdef NIGHT_FLASH_EN
      NIGHT: begin
        la_nxt  = flash_nxt ? 3'b010 : 3'b000;
        lb_nxt  = flash_nxt ? 3'b100 : 3'b000;
        hex_nxt = 7'b1111111;
      end
`endif
      default: ;
    endcase
  end

  assign LED   = led;
  assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Directed bench for traffic_light_ctrl_param with 4-cycle seconds.
module tb_traffic_light_ctrl_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
  logic       night = 1'b0;
`endif
  logic [2:0] LightA, LightB, phase;
  logic [0:6] HEX;
  logic       LED;

  int passed = 0;
  int total  = 0;
  int k      = 0;
  int ep, es;
  logic [0:48] led_tab;

  localparam logic [2:0] LA_TAB [0:5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  localparam logic [2:0] LB_TAB [0:5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  traffic_light_ctrl_param #(
    .TICKS_PER_SEC(4), .GREEN_SEC(3), .YELLOW_SEC(2), .ALLRED_SEC(1),
    .PED_SEC(1), .SLOW_HALF(2), .FAST_HALF(1)
  ) dut (
    .clk(clk), .reset(reset), .ped_req(ped_req),
`ifdef NIGHT_FLASH_EN
    .night(night),
`endif
    .LightA(LightA), .LightB(LightB), .HEX(HEX), .LED(LED), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      1:       seg = 7'b1001111;
      2:       seg = 7'b0010010;
      3:       seg = 7'b0000110;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // Expected phase and seconds for cycle c of an undisturbed run from reset release.
  task automatic model(input int c, output int p, output int s);
    if      (c < 12) begin p = 0; s = 3 - c / 4; end
    else if (c < 20) begin p = 1; s = 2 - (c - 12) / 4; end
    else if (c < 24) begin p = 2; s = 1; end
    else if (c < 36) begin p = 3; s = 3 - (c - 24) / 4; end
    else if (c < 44) begin p = 4; s = 2 - (c - 36) / 4; end
    else if (c < 48) begin p = 5; s = 1; end
    else             begin p = 0; s = 3; end
  endtask

  task automatic chk_reset_state();
    chk("rst_lighta", 8'(LightA), 8'(3'b001));
    chk("rst_lightb", 8'(LightB), 8'(3'b100));
    chk("rst_phase",  8'(phase),  8'd0);
    chk("rst_hex",    8'(HEX),    8'(seg(3)));
    chk("rst_led",    8'(LED),    8'd0);
  endtask

  task automatic cyc();
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state();
    @(negedge clk);
    reset = 1'b1;
    k = 0;
  endtask

  initial begin
    led_tab = 49'b001100110011_10101010_0000_001100110011_10101010_0000_0;

    // Free run through a full cycle of six phases.
    do_reset();
    for (int i = 0; i <= 48; i++) begin
      if (i > 0) cyc();
      model(k, ep, es);
      chk("run_phase",  8'(phase),  8'(ep));
      chk("run_hex",    8'(HEX),    8'(seg(es)));
      chk("run_lighta", 8'(LightA), 8'(LA_TAB[ep]));
      chk("run_lightb", 8'(LightB), 8'(LB_TAB[ep]));
      chk("run_led",    8'(LED),    8'(led_tab[k]));
    end

    // Pedestrian pulse early in A_GREEN.
    do_reset();
    chk("ped_hex0", 8'(HEX), 8'(seg(3)));
    cyc(); ped_req = 1'b1;
    cyc(); ped_req = 1'b0;
    chk("ped_hex2", 8'(HEX), 8'(seg(3)));
    cyc();
    chk("ped_hex3",   8'(HEX),   8'(seg(1)));
    chk("ped_phase3", 8'(phase), 8'd0);
    cyc();
    chk("ped_phase4",  8'(phase),  8'd1);
    chk("ped_hex4",    8'(HEX),    8'(seg(2)));
    chk("ped_lighta4", 8'(LightA), 8'(3'b010));

    // Pedestrian request during RED_AB is held until B_GREEN.
    do_reset();
    while (k < 21) cyc();
    chk("red_phase21", 8'(phase), 8'd2);
    ped_req = 1'b1;
    cyc(); ped_req = 1'b0;
    chk("red_lighta22", 8'(LightA), 8'(3'b100));
    chk("red_lightb22", 8'(LightB), 8'(3'b100));
    chk("red_phase22",  8'(phase),  8'd2);
    cyc();
    chk("red_phase23",  8'(phase),  8'd2);
    cyc();
    chk("bg_phase24",  8'(phase),  8'd3);
    chk("bg_hex24",    8'(HEX),    8'(seg(3)));
    chk("bg_lightb24", 8'(LightB), 8'(3'b001));
    cyc();
    chk("bg_hex25", 8'(HEX), 8'(seg(1)));
    cyc();
    chk("bg_hex26", 8'(HEX), 8'(seg(1)));
    cyc();
    chk("bg_phase27", 8'(phase), 8'd3);
    cyc();
    chk("by_phase28",  8'(phase),  8'd4);
    chk("by_hex28",    8'(HEX),    8'(seg(2)));
    chk("by_lightb28", 8'(LightB), 8'(3'b010));
    cyc(); cyc();
    chk("by_phase30", 8'(phase), 8'd4);

    // Asynchronous reset in the middle of B_YELLOW, then restart.
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state();
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) cyc();
      model(k, ep, es);
      chk("rel_phase", 8'(phase), 8'(ep));
      chk("rel_hex",   8'(HEX),   8'(seg(es)));
      chk("rel_led",   8'(LED),   8'(led_tab[k]));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
